// File: rtl/div_clk_unit_if.sv
// Bundle of the five divided clock outputs produced by div_clk_unit.
// The master modport drives the clocks and the slave modport consumes them.
interface div_clk_unit_if;
    logic div_2_o;
    logic div_4_o;
    logic div_8_o;
    logic div_3_o;
    logic div_n_o;

    modport master (
        output div_2_o,
        output div_4_o,
        output div_8_o,
        output div_3_o,
        output div_n_o
    );

    modport slave (
        input div_2_o,
        input div_4_o,
        input div_8_o,
        input div_3_o,
        input div_n_o
    );
endinterface

// File: rtl/div_clk_unit.sv
// Free-running clock divider: /2, /4, /8 from a binary counter, /3 and /DIV_N
// with 50% duty (odd ratios stretch a rising-edge pulse with a falling-edge copy).
module div_clk_unit #(
    parameter int DIV_N = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    div_clk_unit_if.master     div_out
);

    if ((DIV_N < 2) || (DIV_N > 256)) begin : g_bad_div_n
        $error("div_clk_unit: DIV_N must be within 2..256");
    end

    localparam int             CW        = (DIV_N > 2) ? $clog2(DIV_N) : 1;
    localparam logic           IS_ODD    = ((DIV_N % 2) == 1) ? 1'b1 : 1'b0;
    // Odd ratios cycle through the full range; even ratios only need half of it.
    localparam logic [CW-1:0]  MODN_LAST = IS_ODD ? CW'(DIV_N - 1) : CW'((DIV_N / 2) - 1);
    localparam logic [CW-1:0]  HIGH_MAX  = CW'((DIV_N - 1) / 2);
    localparam logic [CW-1:0]  MODN_ONE  = CW'(1);

    logic [2:0]     bin_cnt_r;
    logic [1:0]     mod3_cnt_r;
    logic [1:0]     mod3_nxt_s;
    logic           div3_pos_r;
    logic           div3_neg_r;
    logic [CW-1:0]  modn_cnt_r;
    logic [CW-1:0]  modn_nxt_s;
    logic           divn_pos_nxt_s;
    logic           divn_pos_r;
    logic           divn_neg_r;

    // Next-state for the mod-3 and mod-DIV_N counters and the DIV_N rising-edge flop.
    always_comb begin
        mod3_nxt_s     = 2'd0;
        modn_nxt_s     = '0;
        divn_pos_nxt_s = 1'b0;
        if (mod3_cnt_r == 2'd2) begin
            mod3_nxt_s = 2'd0;
        end else begin
            mod3_nxt_s = mod3_cnt_r + 2'd1;
        end
        if (modn_cnt_r == MODN_LAST) begin
            modn_nxt_s = '0;
        end else begin
            modn_nxt_s = modn_cnt_r + MODN_ONE;
        end
        if (IS_ODD) begin
            divn_pos_nxt_s = (modn_nxt_s != '0) && (modn_nxt_s <= HIGH_MAX);
        end else if (modn_cnt_r == MODN_LAST) begin
            divn_pos_nxt_s = ~divn_pos_r;
        end else begin
            divn_pos_nxt_s = divn_pos_r;
        end
    end

    // Rising-edge state: binary counter, mod-3 / mod-DIV_N counters and their flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_cnt_r  <= 3'd0;
            mod3_cnt_r <= 2'd0;
            div3_pos_r <= 1'b0;
            modn_cnt_r <= '0;
            divn_pos_r <= 1'b0;
        end else begin
            bin_cnt_r  <= bin_cnt_r + 3'd1;
            mod3_cnt_r <= mod3_nxt_s;
            div3_pos_r <= (mod3_nxt_s == 2'd1);
            modn_cnt_r <= modn_nxt_s;
            divn_pos_r <= divn_pos_nxt_s;
        end
    end

    // Falling-edge copies stretch the odd-ratio pulses by half a clk_i period.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div3_neg_r <= 1'b0;
            divn_neg_r <= 1'b0;
        end else begin
            div3_neg_r <= div3_pos_r;
            divn_neg_r <= divn_pos_r & IS_ODD;
        end
    end

    assign div_out.div_2_o = bin_cnt_r[0];
    assign div_out.div_4_o = bin_cnt_r[1];
    assign div_out.div_8_o = bin_cnt_r[2];
    assign div_out.div_3_o = div3_pos_r | div3_neg_r;
    assign div_out.div_n_o = divn_pos_r | divn_neg_r;

endmodule

// File: tb/tb_div_clk_unit.sv
// Directed bench for div_clk_unit with DIV_N=5 and DIV_N=4 instances sharing
// one 10-unit clock; outputs are sampled 1 unit after each clock edge.
module tb_div_clk_unit;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_clk_unit_if if5 ();
    div_clk_unit_if if4 ();

    div_clk_unit #(.DIV_N(5)) dut5 (.clk_i(clk), .rst_i(rst), .div_out(if5.master));
    div_clk_unit #(.DIV_N(4)) dut4 (.clk_i(clk), .rst_i(rst), .div_out(if4.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [9:0] all_outs;
    assign all_outs = {if5.div_2_o, if5.div_4_o, if5.div_8_o, if5.div_3_o, if5.div_n_o,
                       if4.div_2_o, if4.div_4_o, if4.div_8_o, if4.div_3_o, if4.div_n_o};

    // Minimum interval between successive changes of each output while monitoring.
    logic       mon_en;
    logic [9:0] prev_outs;
    logic [9:0] seen;
    time        last_chg [10];
    time        min_w [10];

    always @(all_outs) begin
        if (mon_en) begin
            for (int b = 0; b < 10; b++) begin
                if (all_outs[b] !== prev_outs[b]) begin
                    if (seen[b] && (($time - last_chg[b]) < min_w[b])) begin
                        min_w[b] = $time - last_chg[b];
                    end
                    seen[b]     = 1'b1;
                    last_chg[b] = $time;
                end
            end
        end
        prev_outs = all_outs;
    end

    task automatic release_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // h even: sample after rising edge h/2+1; h odd: after the following falling edge.
    task automatic next_half(input int h);
        if ((h % 2) == 0) begin
            @(posedge clk);
        end else begin
            @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== 10'b0) begin
            errors++;
            $display("FAIL reset_initial: got %b expected %b", all_outs, 10'b0);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (all_outs !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %b expected %b", i, all_outs, 10'b0);
            end
        end
    endtask

    task automatic test_binary_divs;
        logic [2:0] exp_bin;
        int         k;
        release_reset();
        checks++;
        if (all_outs !== 10'b0) begin
            errors++;
            $display("FAIL bin_before_edge: got %b expected %b", all_outs, 10'b0);
        end
        for (int h = 0; h < 34; h++) begin
            next_half(h);
            k       = (h / 2) + 1;
            exp_bin = 3'(k % 8);
            checks++;
            if ({if5.div_8_o, if5.div_4_o, if5.div_2_o} !== exp_bin) begin
                errors++;
                $display("FAIL bin_div5 half %0d: got %b expected %b", h,
                         {if5.div_8_o, if5.div_4_o, if5.div_2_o}, exp_bin);
            end
            checks++;
            if ({if4.div_8_o, if4.div_4_o, if4.div_2_o} !== exp_bin) begin
                errors++;
                $display("FAIL bin_div4 half %0d: got %b expected %b", h,
                         {if4.div_8_o, if4.div_4_o, if4.div_2_o}, exp_bin);
            end
        end
    endtask

    task automatic test_div3;
        logic [5:0] p3;
        p3 = 6'b000111;
        release_reset();
        for (int h = 0; h < 24; h++) begin
            next_half(h);
            checks++;
            if ({if5.div_3_o, if4.div_3_o} !== {2{p3[h % 6]}}) begin
                errors++;
                $display("FAIL div3 half %0d: got %b expected %b", h,
                         {if5.div_3_o, if4.div_3_o}, {2{p3[h % 6]}});
            end
        end
    endtask

    task automatic test_div_n;
        logic [9:0] p5;
        logic [7:0] p4;
        p5 = 10'b0000011111;
        p4 = 8'b00111100;
        release_reset();
        for (int h = 0; h < 40; h++) begin
            next_half(h);
            checks++;
            if (if5.div_n_o !== p5[h % 10]) begin
                errors++;
                $display("FAIL divn5 half %0d: got %b expected %b", h, if5.div_n_o, p5[h % 10]);
            end
            checks++;
            if (if4.div_n_o !== p4[h % 8]) begin
                errors++;
                $display("FAIL divn4 half %0d: got %b expected %b", h, if4.div_n_o, p4[h % 8]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [5:0] p3;
        logic [9:0] p5;
        logic [2:0] exp_bin;
        p3 = 6'b000111;
        p5 = 10'b0000011111;
        release_reset();
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if ({if5.div_3_o, clk} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: got div3/clk %b expected %b", {if5.div_3_o, clk}, 2'b11);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== 10'b0) begin
            errors++;
            $display("FAIL midrst_async: got %b expected %b", all_outs, 10'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (all_outs !== 10'b0) begin
                errors++;
                $display("FAIL midrst_hold edge %0d: got %b expected %b", i, all_outs, 10'b0);
            end
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int h = 0; h < 12; h++) begin
            next_half(h);
            exp_bin = 3'(((h / 2) + 1) % 8);
            checks++;
            if ({if5.div_8_o, if5.div_4_o, if5.div_2_o, if5.div_3_o, if5.div_n_o} !==
                {exp_bin, p3[h % 6], p5[h % 10]}) begin
                errors++;
                $display("FAIL midrst_restart half %0d: got %b expected %b", h,
                         {if5.div_8_o, if5.div_4_o, if5.div_2_o, if5.div_3_o, if5.div_n_o},
                         {exp_bin, p3[h % 6], p5[h % 10]});
            end
        end
    endtask

    task automatic test_glitch;
        logic prev8;
        logic prev4;
        logic prev2;
        int   rises;
        rst = 1'b1;
        #1;
        for (int b = 0; b < 10; b++) begin
            min_w[b]    = 1000000;
            last_chg[b] = 0;
        end
        seen   = 10'b0;
        mon_en = 1'b1;
        release_reset();
        prev8 = if5.div_8_o;
        prev4 = if5.div_4_o;
        prev2 = if5.div_2_o;
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if ((prev8 === 1'b0) && (if5.div_8_o === 1'b1)) begin
                rises++;
                checks++;
                if ({prev4, prev2} !== 2'b11) begin
                    errors++;
                    $display("FAIL div8_rise_align cycle %0d: got div4/div2 %b expected %b",
                             i, {prev4, prev2}, 2'b11);
                end
            end
            prev8 = if5.div_8_o;
            prev4 = if5.div_4_o;
            prev2 = if5.div_2_o;
        end
        mon_en = 1'b0;
        checks++;
        if (rises !== 13) begin
            errors++;
            $display("FAIL div8_rise_count: got %0d expected %0d", rises, 13);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if ((seen[b] !== 1'b1) || (min_w[b] < 5)) begin
                errors++;
                $display("FAIL min_pulse bit %0d: got seen=%b width=%0t expected width>=5",
                         b, seen[b], min_w[b]);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        mon_en    = 1'b0;
        seen      = 10'b0;
        prev_outs = 10'b0;
        rst       = 1'b1;
        test_reset();
        test_binary_divs();
        test_div3();
        test_div_n();
        test_mid_reset();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
